uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 34 +++
 rtl/uart_rx.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial-side and word-side signals of the UART receiver.
// The master modport is the receiver itself; the slave modport is the
// consumer that owns the pin and enable and sees the received words.
interface uart_rx_if #(
  parameter int PAYLOAD_BITS = 8
);
  logic                    uart_rxd;
  logic                    uart_rx_en;
  logic                    uart_rx_valid;
  logic [PAYLOAD_BITS-1:0] uart_rx_data;
  logic                    uart_rx_ferr;
  logic                    uart_rx_break;
  logic                    uart_rx_perr;

  modport master (
    input  uart_rxd,
    input  uart_rx_en,
    output uart_rx_valid,
    output uart_rx_data,
    output uart_rx_ferr,
    output uart_rx_break,
    output uart_rx_perr
  );

  modport slave (
    output uart_rxd,
    output uart_rx_en,
    input  uart_rx_valid,
    input  uart_rx_data,
    input  uart_rx_ferr,
    input  uart_rx_break,
    input  uart_rx_perr
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with mid-bit sampling, framing-error
// and break detection. Frame is start, PAYLOAD_BITS data (LSB first), stop.
// Optional feature: define UART_RX_PARITY_EN to add one even-parity bit
// between data and stop and make uart_rx_perr live; otherwise perr is 0.
module uart_rx #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50000000,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.master rx
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CNT_W          = $clog2(CYCLES_PER_BIT + 1);
  localparam int BIT_W          = $clog2(PAYLOAD_BITS + 1);

  // Counter values at which a sample is taken (counter reloads to 0 there).
  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(PAYLOAD_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    ferr_q, ferr_d;
  logic                    brk_q, brk_d;
  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  logic                    rxd_meta_q, rxd_meta_d;
  logic                    rxd_sync_q, rxd_sync_d;
  logic                    rxd_prev_q, rxd_prev_d;
`ifdef UART_RX_PARITY_EN
  logic                    parity_q, parity_d;
  logic                    perr_q, perr_d;
`endif

  // Next-state, sampling and output-pulse logic; pulses default low each cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    brk_d      = 1'b0;
    rxd_meta_d = rx.uart_rxd;
    rxd_sync_d = rxd_meta_q;
    rxd_prev_d = rxd_sync_q;
`ifdef UART_RX_PARITY_EN
    parity_d   = parity_q;
    perr_d     = 1'b0;
`endif

    unique case (state_q)
      // Enable only gates the start edge; a frame in flight always completes.
      IDLE: begin
        if (rx.uart_rx_en && rxd_prev_q && !rxd_sync_q) begin
          state_d   = START;
          cnt_d     = '0;
          bit_cnt_d = '0;
        end
      end

      // Re-check the start bit at its middle to reject short glitches.
      START: begin
        if (cnt_q == CNT_HALF_END) begin
          cnt_d   = '0;
          state_d = rxd_sync_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d   = '0;
          shift_d = {rxd_sync_q, shift_q[PAYLOAD_BITS-1:1]};
          if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d    = '0;
          parity_d = rxd_sync_q;
          state_d  = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      // A low stop bit is a framing error; the word is dropped and the
      // line must return high before another start can be seen.
      STOP: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d = '0;
          if (rxd_sync_q) begin
            valid_d = 1'b1;
            data_d  = shift_q;
`ifdef UART_RX_PARITY_EN
            perr_d  = parity_q != (^shift_q);
`endif
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            brk_d   = (shift_q == '0);
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_HIGH: begin
        if (rxd_sync_q) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, datapath and synchronizer registers; reset discards any frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
      parity_q   <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
      rxd_meta_q <= rxd_meta_d;
      rxd_sync_q <= rxd_sync_d;
      rxd_prev_q <= rxd_prev_d;
`ifdef UART_RX_PARITY_EN
      parity_q   <= parity_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign rx.uart_rx_valid = valid_q;
  assign rx.uart_rx_data  = data_q;
  assign rx.uart_rx_ferr  = ferr_q;
  assign rx.uart_rx_break = brk_q;
`ifdef UART_RX_PARITY_EN
  assign rx.uart_rx_perr  = perr_q;
`else
  assign rx.uart_rx_perr  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. Stimulus serializes frames on
// the pin and pushes the expected outcome of each frame; a monitor pops an
// entry whenever the receiver pulses and compares. Clock/baud are scaled
// down so each bit is 16 clocks.
module tb_uart_rx;
  localparam int CLK_HZ       = 160;
  localparam int BIT_RATE     = 10;
  localparam int PAYLOAD_BITS = 8;
  localparam int CPB          = CLK_HZ / BIT_RATE;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_rx_if #(.PAYLOAD_BITS(PAYLOAD_BITS)) bus ();

  uart_rx #(
    .BIT_RATE    (BIT_RATE),
    .CLK_HZ      (CLK_HZ),
    .PAYLOAD_BITS(PAYLOAD_BITS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rx   (bus)
  );

  typedef struct packed {
    logic       is_ferr;
    logic       brk;
    logic       perr;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(logic b);
    bus.uart_rxd = b;
    tick(CPB);
  endtask

  // Reference model: a frame with a high stop bit delivers its word (perr
  // set when the transmitted parity bit disagrees with even parity); a low
  // stop bit is a framing error, a break when the word is zero, and leaves
  // the previously delivered word on the data output.
  // en_mode: 0 enabled, 1 enable dropped during bit 3, 2 disabled throughout.
  task automatic send_frame(logic [7:0] d, logic stop, logic par_flip,
                            int en_mode, int gap);
    exp_t e;
    if (en_mode != 2) begin
      if (stop) begin
        e = '{is_ferr: 1'b0, brk: 1'b0, perr: par_flip, data: d};
        last_good = d;
      end else begin
        e = '{is_ferr: 1'b1, brk: (d == 8'h00), perr: 1'b0, data: last_good};
      end
      exp_q.push_back(e);
    end
    bus.uart_rx_en = (en_mode != 2);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (en_mode == 1 && i == 3) bus.uart_rx_en = 1'b0;
      drive_bit(d[i]);
    end
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`endif
    drive_bit(stop);
    bus.uart_rxd = 1'b1;
    tick(gap);
    bus.uart_rx_en = 1'b1;
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && (bus.uart_rx_valid || bus.uart_rx_ferr ||
                   bus.uart_rx_break || bus.uart_rx_perr)) begin
      check("valid_ferr_exclusive", 32'(bus.uart_rx_valid & bus.uart_rx_ferr), 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: valid=%0b ferr=%0b break=%0b perr=%0b required none at %0t",
                 bus.uart_rx_valid, bus.uart_rx_ferr, bus.uart_rx_break,
                 bus.uart_rx_perr, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("valid", 32'(bus.uart_rx_valid), 32'(!mon_e.is_ferr));
        check("ferr",  32'(bus.uart_rx_ferr), 32'(mon_e.is_ferr));
        check("break", 32'(bus.uart_rx_break), 32'(mon_e.brk));
        check("perr",  32'(bus.uart_rx_perr), 32'(mon_e.perr));
        check("data",  32'(bus.uart_rx_data), 32'(mon_e.data));
      end
    end
  end

  // Hang guard.
  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish within 60000 cycles");
    $fatal(1);
  end

  task automatic check_all_low(string tag);
    check({tag, "_valid"}, 32'(bus.uart_rx_valid), 0);
    check({tag, "_ferr"},  32'(bus.uart_rx_ferr), 0);
    check({tag, "_break"}, 32'(bus.uart_rx_break), 0);
    check({tag, "_perr"},  32'(bus.uart_rx_perr), 0);
    check({tag, "_data"},  32'(bus.uart_rx_data), 0);
  endtask

  initial begin
    logic [7:0] rd;
    logic       rs;
    logic       rp;
    reset          = 1'b1;
    bus.uart_rxd   = 1'b1;
    bus.uart_rx_en = 1'b1;
    tick(3);
    check_all_low("reset");
    reset = 1'b0;
    tick(2 * CPB);

    // Two clean frames.
    send_frame(8'hA5, 1'b1, 1'b0, 0, CPB);
    send_frame(8'h3C, 1'b1, 1'b0, 0, CPB);

    // Short low glitch on idle line: rejected, next frame still received.
    bus.uart_rxd = 1'b0;
    tick(CPB / 4);
    bus.uart_rxd = 1'b1;
    tick(2 * CPB);
    send_frame(8'h81, 1'b1, 1'b0, 0, CPB);

    // Low stop bit, line held low three more bits, then a good frame.
    send_frame(8'h55, 1'b0, 1'b0, 0, 0);
    bus.uart_rxd = 1'b0;
    tick(3 * CPB);
    bus.uart_rxd = 1'b1;
    tick(2 * CPB);
    send_frame(8'h12, 1'b1, 1'b0, 0, CPB);

    // Break: line low for 20 bit times, then a good frame.
    exp_q.push_back('{is_ferr: 1'b1, brk: 1'b1, perr: 1'b0, data: last_good});
    bus.uart_rxd = 1'b0;
    tick(20 * CPB);
    bus.uart_rxd = 1'b1;
    tick(2 * CPB);
    send_frame(8'hC3, 1'b1, 1'b0, 0, CPB);

    // Enable dropped mid-frame completes; disabled frame is ignored.
    send_frame(8'h6E, 1'b1, 1'b0, 1, CPB);
    send_frame(8'h99, 1'b1, 1'b0, 2, CPB);

    // One-cycle reset in the middle of bit 4 of 0xF0 (line high to the end).
    rd = 8'hF0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(rd[i]);
    bus.uart_rxd = 1'b1;
    tick(CPB / 2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    last_good = 8'h00;
    check_all_low("midreset");
    tick(CPB / 2 + 4 * CPB);
`ifdef UART_RX_PARITY_EN
    tick(CPB);
`endif
    tick(2 * CPB);
    send_frame(8'hFF, 1'b1, 1'b0, 0, CPB);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 0, CPB);
    send_frame(8'h07, 1'b1, 1'b1, 0, CPB);
`endif

    // Randomized frames.
    for (int n = 0; n < 24; n++) begin
      rd = 8'($urandom);
      if ($urandom_range(0, 7) == 0) rd = 8'h00;
      rs = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
      rp = 1'($urandom_range(0, 1));
`else
      rp = 1'b0;
`endif
      send_frame(rd, rs, rp, int'($urandom_range(0, 1)),
                 int'($urandom_range(1, 3)) * CPB);
    end

    tick(4 * CPB);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
